// File: rtl/proc_csr_io_queue.sv
// proc_csr_io_queue
//   CSR I/O unit for TinyRV1: NUM_OUT output channels fed by W-stage CSR
//   writes and NUM_IN input channels drained by CSR reads. Each channel has
//   its own DEPTH-entry FIFO with val/rdy handshakes on the pin side.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   csrw_en/sel/data    CSR write into output FIFO csrw_sel
//   csrw_stall          selected output FIFO is full
//   csrr_en/sel         CSR read: sel[3]=0 input channel sel[2:0], sel[3]=1 status
//   csrr_data           combinational read data (head entry or status word)
//   csrr_stall          selected input FIFO is empty
//   out_val/rdy/data    output channel handshakes, channel i at [i*DATA_W +: DATA_W]
//   in_val/rdy/data     input channel handshakes, same packing
module proc_csr_io_queue #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csrw_en,
  input  logic [2:0]                csrw_sel,
  input  logic [DATA_W-1:0]         csrw_data,
  output logic                      csrw_stall,
  input  logic                      csrr_en,
  input  logic [3:0]                csrr_sel,
  output logic [DATA_W-1:0]         csrr_data,
  output logic                      csrr_stall,
  output logic [NUM_OUT-1:0]        out_val,
  input  logic [NUM_OUT-1:0]        out_rdy,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_IN-1:0]         in_val,
  output logic [NUM_IN-1:0]         in_rdy,
  input  logic [NUM_IN*DATA_W-1:0]  in_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NUM_OUT-1:0]        o_full;
  logic [NUM_IN-1:0]         i_empty;
  logic [NUM_IN*DATA_W-1:0]  i_head;
  logic [DATA_W-1:0]         status;

  // Output channels: pushed by CSR writes, popped by the external sink.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full, empty, push, pop;

    always_comb begin
      full   = (cnt_q == CW'(DEPTH));
      empty  = (cnt_q == '0);
      // Out-of-range selects never match any generated channel, so they
      // fall through as ignored writes.
      push   = csrw_en && (csrw_sel == 3'(gi)) && !full;
      pop    = !empty && out_rdy[gi];
      wptr_d = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= csrw_data;
    end

    assign o_full[gi]                        = full;
    assign out_val[gi]                       = !empty;
    assign out_data[gi*DATA_W +: DATA_W]     = mem_q[rptr_q];
  end

  // Input channels: pushed by the external source, popped by CSR reads.
  for (genvar gj = 0; gj < NUM_IN; gj++) begin : g_in
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              full, empty, push, pop;

    always_comb begin
      full   = (cnt_q == CW'(DEPTH));
      empty  = (cnt_q == '0);
      push   = in_val[gj] && !full;
      pop    = csrr_en && !csrr_sel[3] && (csrr_sel[2:0] == 3'(gj)) && !empty;
      wptr_d = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in_data[gj*DATA_W +: DATA_W];
    end

    assign i_empty[gj]                   = empty;
    assign in_rdy[gj]                    = !full;
    assign i_head[gj*DATA_W +: DATA_W]   = mem_q[rptr_q];
  end

  always_comb begin
    csrw_stall = 1'b0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (csrw_en && (csrw_sel == 3'(i)) && o_full[i]) csrw_stall = 1'b1;
    end
  end

  // Status word: bit j = input j has data, bit 8+i = output i has space.
  always_comb begin
    status = '0;
    for (int unsigned j = 0; j < NUM_IN; j++)  status[j]     = !i_empty[j];
    for (int unsigned i = 0; i < NUM_OUT; i++) status[8 + i] = !o_full[i];
  end

  always_comb begin
    csrr_stall = 1'b0;
    csrr_data  = '0;
    if (csrr_en) begin
      if (csrr_sel[3]) begin
        csrr_data = status;
      end else begin
        for (int unsigned j = 0; j < NUM_IN; j++) begin
          if (csrr_sel[2:0] == 3'(j)) begin
            if (i_empty[j]) csrr_stall = 1'b1;
            else            csrr_data  = i_head[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_csr_io_queue.sv
module tb_proc_csr_io_queue;
  localparam int DW = 32;
  localparam int NO = 3;
  localparam int NI = 3;
  localparam int D  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           csrw_en;
  logic [2:0]     csrw_sel;
  logic [DW-1:0]  csrw_data;
  logic           csrw_stall;
  logic           csrr_en;
  logic [3:0]     csrr_sel;
  logic [DW-1:0]  csrr_data;
  logic           csrr_stall;
  logic [NO-1:0]  out_val;
  logic [NO-1:0]  out_rdy;
  logic [NO*DW-1:0] out_data;
  logic [NI-1:0]  in_val;
  logic [NI-1:0]  in_rdy;
  logic [NI*DW-1:0] in_data;

  always #5 clk = ~clk;

  proc_csr_io_queue #(.DATA_W(DW), .NUM_OUT(NO), .NUM_IN(NI), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .csrw_en(csrw_en), .csrw_sel(csrw_sel), .csrw_data(csrw_data), .csrw_stall(csrw_stall),
    .csrr_en(csrr_en), .csrr_sel(csrr_sel), .csrr_data(csrr_data), .csrr_stall(csrr_stall),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data)
  );

  // Reference model: one queue per FIFO.
  logic [31:0] oq [NO][$];
  logic [31:0] iq [NI][$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s = '0;
    for (int j = 0; j < NI; j++) s[j]     = (iq[j].size() != 0);
    for (int i = 0; i < NO; i++) s[8 + i] = (oq[i].size() != D);
    return s;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NO; i++) oq[i].delete();
    for (int j = 0; j < NI; j++) iq[j].delete();
  endtask

  task automatic check_outputs();
    logic [31:0] ev, er, ws, rs, rd;
    ev = '0; er = '0; ws = '0; rs = '0; rd = '0;
    for (int i = 0; i < NO; i++) ev[i] = (oq[i].size() != 0);
    for (int j = 0; j < NI; j++) er[j] = (iq[j].size() < D);
    chk("out_val", 32'(out_val), ev);
    chk("in_rdy", 32'(in_rdy), er);
    for (int i = 0; i < NO; i++)
      if (oq[i].size() != 0) chk($sformatf("out_data%0d", i), out_data[i*DW +: DW], oq[i][0]);
    if (csrw_en && int'(csrw_sel) < NO)
      if (oq[csrw_sel].size() == D) ws = 1;
    if (csrr_en) begin
      if (csrr_sel[3]) rd = model_status();
      else if (int'(csrr_sel[2:0]) < NI) begin
        if (iq[csrr_sel[2:0]].size() == 0) rs = 1;
        else rd = iq[csrr_sel[2:0]][0];
      end
    end
    chk("csrw_stall", 32'(csrw_stall), ws);
    chk("csrr_stall", 32'(csrr_stall), rs);
    chk("csrr_data", csrr_data, rd);
  endtask

  // Apply one clock edge worth of transfers using pre-edge occupancy.
  task automatic update_model();
    int osz [NO];
    int isz [NI];
    if (!rst) begin
      clear_model();
      return;
    end
    for (int i = 0; i < NO; i++) osz[i] = oq[i].size();
    for (int j = 0; j < NI; j++) isz[j] = iq[j].size();
    for (int i = 0; i < NO; i++) begin
      if (osz[i] > 0 && out_rdy[i]) void'(oq[i].pop_front());
      if (csrw_en && int'(csrw_sel) == i && osz[i] < D) oq[i].push_back(csrw_data);
    end
    for (int j = 0; j < NI; j++) begin
      if (csrr_en && !csrr_sel[3] && int'(csrr_sel[2:0]) == j && isz[j] > 0) void'(iq[j].pop_front());
      if (in_val[j] && isz[j] < D) iq[j].push_back(in_data[j*DW +: DW]);
    end
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    csrw_en = 0; csrw_sel = 0; csrw_data = 0;
    csrr_en = 0; csrr_sel = 0;
    out_rdy = 0; in_val = 0; in_data = '0;
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
    rst = 0;
    idle();
    clear_model();
    @(negedge clk);
    #1;
    chk("rst_out_val", 32'(out_val), 32'h0);
    chk("rst_in_rdy", 32'(in_rdy), 32'h7);
    chk("rst_csrr_data", csrr_data, 32'h0);
    step();
    rst = 1;
    step();

    // Fill output ch1 with the sink stalled; fifth write must stall.
    for (int k = 0; k < 4; k++) begin
      csrw_en = 1; csrw_sel = 1; csrw_data = exp_seq[k];
      #1; step();
    end
    csrw_data = 32'h55;
    #1;
    chk("wr5_stall", 32'(csrw_stall), 32'h1);
    out_rdy = 3'b010;  // pop in the same cycle must not clear the stall
    #1;
    chk("wr5_stall_pop", 32'(csrw_stall), 32'h1);
    step();
    csrw_en = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("drain%0d", k + 1), out_data[1*DW +: DW], exp_seq[k + 1]);
      step();
    end
    #1;
    chk("drained", 32'(out_val[1]), 32'h0);
    step();

    // Read of empty input ch0 while the source pushes: stall, no bypass.
    idle();
    csrr_en = 1; csrr_sel = 4'h0; in_val = 3'b001; in_data[0 +: 32] = 32'hAB;
    #1;
    chk("rd_empty_stall", 32'(csrr_stall), 32'h1);
    chk("rd_empty_data", csrr_data, 32'h0);
    step();
    in_val = 0;
    #1;
    chk("rd_next_data", csrr_data, 32'hAB);
    chk("rd_next_stall", 32'(csrr_stall), 32'h0);
    step();

    // Fill input ch2, then read+push at full and at steady occupancy.
    idle();
    for (int k = 0; k < 4; k++) begin
      in_val = 3'b100; in_data[64 +: 32] = 32'h100 + 32'(k);
      #1; step();
    end
    in_val = 0;
    #1;
    chk("in2_full_rdy", 32'(in_rdy[2]), 32'h0);
    step();
    csrr_en = 1; csrr_sel = 4'h2; in_val = 3'b100; in_data[64 +: 32] = 32'h55;
    #1; step();
    for (int k = 0; k < 12; k++) begin
      in_data[64 +: 32] = 32'h60 + 32'(k);
      #1; step();
    end
    idle();
    #1; step();

    // Asynchronous reset with two entries queued.
    csrw_en = 1; csrw_sel = 0; csrw_data = 32'hA1;
    #1; step();
    csrw_data = 32'hA2;
    #1; step();
    idle();
    #1;
    chk("pre_rst_val", 32'(out_val[0]), 32'h1);
    #2 rst = 0;
    #1;
    chk("mid_rst_out_val", 32'(out_val), 32'h0);
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'h7);
    clear_model();
    @(negedge clk);
    rst = 1;
    #1; step();

    // Status word: input ch0 holds one entry, output ch1 full.
    in_val = 3'b001; in_data[0 +: 32] = 32'hC0DE;
    #1; step();
    in_val = 0;
    for (int k = 0; k < 4; k++) begin
      csrw_en = 1; csrw_sel = 1; csrw_data = 32'h200 + 32'(k);
      #1; step();
    end
    idle();
    csrr_en = 1; csrr_sel = 4'h8;
    #1;
    chk("status_word", csrr_data, 32'h0000_0501);
    chk("status_stall", 32'(csrr_stall), 32'h0);
    step();
    step();
    csrr_sel = 4'h0;
    #1;
    chk("status_no_pop", csrr_data, 32'hC0DE);
    step();

    // Out-of-range channel selects.
    idle();
    csrw_en = 1; csrw_sel = 5; csrw_data = 32'hDEAD;
    csrr_en = 1; csrr_sel = 4'h6;
    #1;
    chk("oor_wstall", 32'(csrw_stall), 32'h0);
    chk("oor_rstall", 32'(csrr_stall), 32'h0);
    chk("oor_rdata", csrr_data, 32'h0);
    step();
    idle();
    #1; step();

    // Randomised traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      csrw_en   = ($urandom_range(0, 2) != 0);
      csrw_sel  = 3'($urandom_range(0, 7));
      csrw_data = $urandom;
      csrr_en   = ($urandom_range(0, 2) != 0);
      csrr_sel  = ($urandom_range(0, 5) == 0) ? 4'h8 : 4'($urandom_range(0, 4));
      out_rdy   = 3'($urandom);
      in_val    = 3'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      #1; step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
